// File: rtl/fifo_window_rd.sv
// ---------------------------------------------------------------------------
// fifo_window_rd
//   Windowed-read FIFO. One word can be pushed per cycle. A read presents up
//   to NUM_RDATA consecutive words, with lane 0 as the oldest word, and then
//   pops a variable number of words (0..NUM_RDATA). A step of 0 is a peek.
//   Partial reads are allowed on request and are flagged lane by lane through
//   rd_lane_vld. The read window is registered, so data appears one cycle
//   after the read is accepted.
//
// Ports
//   clk, rst      clock (rising edge); asynchronous active-high reset
//   wr_req/data   push request and the word to push; ignored while full
//   rd_req        read request; accepted when rd_ready is high
//   rd_partial    allow a read when fewer than NUM_RDATA words are stored
//   rd_step       number of words to pop on an accepted read
//   rd_ready      combinational: a read would be accepted this cycle
//   rd_data       window, lane k = [k*DAT_WIDTH +: DAT_WIDTH]
//   rd_data_vld   window valid (one cycle after accept)
//   rd_lane_vld   per-lane valid mask for the window
//   data_counter  number of words stored
//   almost_full   data_counter >= FF_DEPTH-AF_MARGIN
//   full, empty   occupancy flags
// ---------------------------------------------------------------------------
module fifo_window_rd #(
    parameter int NUM_RDATA     = 3,
    parameter int DAT_WIDTH     = 8,
    parameter int FF_ADDR_WIDTH = 3,
    parameter int STEP_WIDTH    = 3,
    parameter int AF_MARGIN     = 2,
    parameter int ZERO_IDLE     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_req,
    input  logic [DAT_WIDTH-1:0]           wr_data,
    input  logic                           rd_req,
    input  logic                           rd_partial,
    input  logic [STEP_WIDTH-1:0]          rd_step,
    output logic                           rd_ready,
    output logic [DAT_WIDTH*NUM_RDATA-1:0] rd_data,
    output logic                           rd_data_vld,
    output logic [NUM_RDATA-1:0]           rd_lane_vld,
    output logic [FF_ADDR_WIDTH:0]         data_counter,
    output logic                           almost_full,
    output logic                           full,
    output logic                           empty
);

    localparam int FF_DEPTH = 2 ** FF_ADDR_WIDTH;
    localparam int PW       = FF_ADDR_WIDTH + 1;
    localparam int CW       = (STEP_WIDTH > PW) ? STEP_WIDTH : PW;

    localparam logic [PW-1:0] LP_DEPTH = PW'(FF_DEPTH);
    localparam logic [PW-1:0] LP_NUM   = PW'(NUM_RDATA);
    localparam logic [PW-1:0] LP_AF    = PW'(FF_DEPTH - AF_MARGIN);

    // Storage and pointers. Pointers carry one extra bit so that full and
    // empty can be told apart; they wrap mod 2*FF_DEPTH.
    logic [DAT_WIDTH-1:0]           r_mem [FF_DEPTH];
    logic [PW-1:0]                  r_wr_ptr;
    logic [PW-1:0]                  r_rd_ptr;

    logic [DAT_WIDTH*NUM_RDATA-1:0] r_rd_data;
    logic                           r_rd_vld;
    logic [NUM_RDATA-1:0]           r_lane_vld;

    logic [PW-1:0]                  w_count;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_rd_ready;
    logic                           w_rd_acc;
    logic                           w_wr_acc;
    logic [PW-1:0]                  w_fill;
    logic [CW-1:0]                  w_step_x;
    logic [CW-1:0]                  w_fill_x;
    logic [PW-1:0]                  w_pop;
    logic [FF_ADDR_WIDTH-1:0]       w_addr;
    logic [DAT_WIDTH*NUM_RDATA-1:0] w_win;
    logic [NUM_RDATA-1:0]           w_lane;

    // -----------------------------------------------------------------------
    // Occupancy and handshake
    // -----------------------------------------------------------------------
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == LP_DEPTH);
    assign w_empty    = (w_count == '0);
    assign w_rd_ready = (w_count >= LP_NUM) | (rd_partial & ~w_empty);
    assign w_rd_acc   = rd_req & w_rd_ready;
    // Uses the pre-edge full flag, so a write arriving while full is dropped
    // even if a read frees space on the same edge.
    assign w_wr_acc   = wr_req & ~w_full;

    // Lanes actually filled by this read: min(count, NUM_RDATA)
    assign w_fill     = (w_count < LP_NUM) ? w_count : LP_NUM;

    // Pop amount: min(rd_step, fill). Both operands are compared at a common
    // width so that a wide rd_step cannot alias after truncation.
    assign w_step_x   = CW'(rd_step);
    assign w_fill_x   = CW'(w_fill);
    assign w_pop      = (w_step_x < w_fill_x) ? w_step_x[PW-1:0] : w_fill;

    // -----------------------------------------------------------------------
    // Window gather. The address wraps naturally at FF_DEPTH, so a window
    // that starts near the top of memory continues from address 0.
    // -----------------------------------------------------------------------
    always_comb begin
        w_win  = '0;
        w_lane = '0;
        w_addr = '0;
        for (int unsigned k = 0; k < NUM_RDATA; k++) begin
            w_addr = r_rd_ptr[FF_ADDR_WIDTH-1:0] + FF_ADDR_WIDTH'(k);
            if (PW'(k) < w_fill) begin
                w_win[k*DAT_WIDTH +: DAT_WIDTH] = r_mem[w_addr];
                w_lane[k]                       = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory write (contents are never observable before being written, so
    // no reset is needed here)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[FF_ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + w_pop;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered read window
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_vld   <= 1'b0;
            r_lane_vld <= '0;
        end else if (w_rd_acc) begin
            r_rd_data  <= w_win;
            r_rd_vld   <= 1'b1;
            r_lane_vld <= w_lane;
        end else begin
            r_rd_vld <= 1'b0;
            if (ZERO_IDLE != 0) begin
                r_rd_data  <= '0;
                r_lane_vld <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rd_ready     = w_rd_ready;
    assign rd_data      = r_rd_data;
    assign rd_data_vld  = r_rd_vld;
    assign rd_lane_vld  = r_lane_vld;
    assign data_counter = w_count;
    assign almost_full  = (w_count >= LP_AF);
    assign full         = w_full;
    assign empty        = w_empty;

endmodule
